muldiv: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers, sitting downstream of the register file read ports in the lab CPU. It consumes the two read operands for MULT/MULTU/DIV/DIVU/MTHI/MTLO and computes products and quotient/remainder over multiple cycles. The HI/LO results feed the writeback mux, which steers them into the register file write port for MFHI/MFLO. A start/busy/done handshake lets the pipeline controller stall dependent instructions.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv.sv | 156 +++++++++++++++
 tb/tb_muldiv.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and arithmetic helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // 0x80000000 maps to itself and is then read as an unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline controller and the multiply/divide unit.
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide with HI/LO registers; multiply and divide share
// one 64-bit accumulator and one adder/subtractor, one radix-2 step per cycle.
module muldiv
  import muldiv_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        mul_q, mul_d;
  logic        neg_p_q, neg_p_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] add_x, add_y;
  logic        add_cin;
  logic [33:0] add_sum;
  logic [63:0] prod;
  logic        sgn;
  logic        is_mul;
  logic [31:0] ua, ub;

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor
  // (carry out of bit 33 means the trial subtraction did not borrow).
  always_comb begin
    add_x   = mul_q ? {1'b0, acc_q[63:32]} : acc_q[63:31];
    add_y   = mul_q ? (acc_q[0] ? {1'b0, opnd_q} : 33'd0) : ~{1'b0, opnd_q};
    add_cin = ~mul_q;
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mul_d   = mul_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod    = neg_p_q ? neg64(acc_q) : acc_q;
    sgn     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    is_mul  = ~bus.op[1];
    ua      = sgn ? abs32(bus.a) : bus.a;
    ub      = sgn ? abs32(bus.b) : bus.b;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (op_e'(bus.op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              mul_d   = is_mul;
              opnd_d  = is_mul ? ua : ub;
              acc_d   = {32'd0, (is_mul ? ub : ua)};
              // A zero divisor keeps the all-ones quotient unsigned.
              neg_p_d = sgn & (bus.a[31] ^ bus.b[31]) & (is_mul | (|bus.b));
              neg_r_d = sgn & bus.a[31];
              cnt_d   = 5'(ITER - 1);
              busy_d  = 1'b1;
              state_d = ST_CALC;
            end
            OP_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (mul_q) begin
          acc_d = {add_sum[32:0], acc_q[31:1]};
        end else if (add_sum[33]) begin
          acc_d = {add_sum[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FIX: begin
        if (mul_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else begin
          lo_d = neg_p_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_r_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      mul_q   <= 1'b0;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      mul_q   <= mul_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vectors plus randomized ops against an arithmetic model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] hi_m, lo_m;

  muldiv_if bus ();
  muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sp, sq, sr;
    logic [63:0] v, q, r;
    ia = a;
    ib = b;
    case (op)
      3'd0: begin sp = longint'(ia) * longint'(ib); v = sp; hi_m = v[63:32]; lo_m = v[31:0]; end
      3'd1: begin v = {32'd0, a} * {32'd0, b}; hi_m = v[63:32]; lo_m = v[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin hi_m = a; lo_m = 32'hFFFF_FFFF; end
        else begin
          sq = longint'(ia) / longint'(ib); sr = longint'(ia) % longint'(ib);
          q = sq; r = sr; lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin hi_m = a; lo_m = 32'hFFFF_FFFF; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endfunction

  // Drives a one-cycle start from a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int first, output int cyc, output int busy_n);
    cyc = first;
    busy_n = 0;
    while (bus.done !== 1'b1 && cyc < 80) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [9] = '{3'd1, 3'd0, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2, 3'd0, 3'd2};
    logic [31:0] as  [9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000,
                             32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'd7};
    logic [31:0] bs  [9] = '{32'hFFFF_FFFF, 32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF,
                             32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFE};
    logic [31:0] ehi [9] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0,
                             32'd5, 32'hFFFF_FFFB, 32'h4000_0000, 32'd1};
    logic [31:0] elo [9] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'h8000_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFD};
    int cyc, bn;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(1, cyc, bn);
      model(ops[i], as[i], bs[i]);
      checks++;
      if (cyc !== 34 || bn !== 33 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL dir_timing[%0d]: done_cycle=%0d busy_cycles=%0d busy=%b, required 34 33 0", i, cyc, bn, bus.busy);
      end
      checks++;
      if (bus.hi !== ehi[i] || bus.lo !== elo[i]) begin
        failures++;
        $display("FAIL dir_result[%0d]: hi=%h lo=%h, required hi=%h lo=%h", i, bus.hi, bus.lo, ehi[i], elo[i]);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.hi !== ehi[i]) begin
        failures++;
        $display("FAIL dir_pulse[%0d]: done=%b hi=%h, required 0 %h", i, bus.done, bus.hi, ehi[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    int cyc, bn, exp_cyc;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      exp_cyc = (op >= 3'd4) ? 1 : 34;
      issue(op, a, b);
      wait_done(1, cyc, bn);
      model(op, a, b);
      checks++;
      if (cyc !== exp_cyc) begin
        failures++;
        $display("FAIL rnd_latency[%0d] op=%0d: done_cycle=%0d, required %0d", i, op, cyc, exp_cyc);
      end
      checks++;
      if (bus.hi !== hi_m || bus.lo !== lo_m) begin
        failures++;
        $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
                 i, op, a, b, bus.hi, bus.lo, hi_m, lo_m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_ops();
    int seen;
    for (int k = 6; k < 8; k++) begin
      seen = 0;
      issue(3'(k), 32'hDEAD_BEEF, 32'd3);
      for (int c = 0; c < 6; c++) begin
        if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        @(negedge clk);
      end
      checks++;
      if (seen !== 0 || bus.hi !== hi_m || bus.lo !== lo_m) begin
        failures++;
        $display("FAIL ignored_op%0d: activity=%0d hi=%h lo=%h, required 0 %h %h", k, seen, bus.hi, bus.lo, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    issue(3'd0, 32'hFFFF_FF00, 32'h0001_2345);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd9; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, cyc, bn);
    checks++;
    if (cyc !== 34 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFEDC_BB00) begin
      failures++;
      $display("FAIL busy_ignore: done_cycle=%0d hi=%h lo=%h, required 34 ffffffff fedcbb00", cyc, bus.hi, bus.lo);
    end
    issue(3'd1, 32'd2, 32'd3);
    wait_done(1, cyc, bn);
    checks++;
    if (cyc !== 34 || bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
      failures++;
      $display("FAIL back_to_back: done_cycle=%0d hi=%h lo=%h, required 34 0 6", cyc, bus.hi, bus.lo);
    end
    hi_m = 32'd0; lo_m = 32'd6;
    @(negedge clk);
  endtask

  task automatic test_mthi_reset();
    int cyc, bn, seen;
    issue(3'd4, 32'h0000_1234, 32'd0);
    checks++;
    if (bus.hi !== 32'h0000_1234 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h done=%b busy=%b, required 00001234 1 0", bus.hi, bus.done, bus.busy);
    end
    @(negedge clk);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", bus.busy, bus.done, bus.hi, bus.lo);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_no_done: done_pulses=%0d, required 0", seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_ignored_ops();
    test_back_to_back();
    test_mthi_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
